// File: rtl/apb_reg_pkg.sv
// rtl/apb_reg_pkg.sv - shared register map, field widths and handshake state encoding
package apb_reg_pkg;

    localparam int CTRL_W  = 8;
    localparam int IRQ_W   = 4;
    localparam int FRAME_W = 16;

    localparam logic [11:0] REG_ID        = 12'h000;
    localparam logic [11:0] REG_CTRL      = 12'h004;
    localparam logic [11:0] REG_CASET     = 12'h008;
    localparam logic [11:0] REG_PASET     = 12'h00C;
    localparam logic [11:0] REG_STATUS    = 12'h010;
    localparam logic [11:0] REG_IRQ       = 12'h014;
    localparam logic [11:0] REG_IRQ_MASK  = 12'h018;
    localparam logic [11:0] REG_SCRATCH   = 12'h01C;
    localparam logic [11:0] REG_FRAME_CNT = 12'h020;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } apb_state_e;

    // The map is dense: every word-aligned offset from ID up to FRAME_CNT exists
    function automatic logic is_mapped(input logic [11:0] off);
        return (off <= REG_FRAME_CNT);
    endfunction

endpackage

// File: rtl/apb_slv_fsm.sv
// rtl/apb_slv_fsm.sv - completer handshake FSM with programmable wait-state counter
module apb_slv_fsm
    import apb_reg_pkg::*;
#(
    parameter int WAIT_STATES = 2
) (
    input  logic        cpuclk,
    input  logic        rst,
    input  logic        psel,
    input  logic [19:0] paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [19:0] addr_o,
    output logic [31:0] wdata_o,
    output logic        wr_stb_o,
    output logic        pready_o
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    apb_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic        pready_q, pready_d;
    logic        wr_stb_q, wr_stb_d;

    // Next-state logic; pready and the write strobe are decided one cycle ahead so both leave as flops
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        pready_d = 1'b0;
        wr_stb_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel) begin
                    addr_d  = paddr;
                    wdata_d = pwdata;
                    write_d = pwrite;
                    if (WAIT_STATES == 0) begin
                        state_d  = RESP;
                        pready_d = 1'b1;
                        wr_stb_d = pwrite;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d  = RESP;
                    pready_d = 1'b1;
                    wr_stb_d = write_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counter, latched request and registered handshake outputs
    always_ff @(posedge cpuclk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 20'd0;
            wdata_q  <= 32'd0;
            write_q  <= 1'b0;
            pready_q <= 1'b0;
            wr_stb_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            pready_q <= pready_d;
            wr_stb_q <= wr_stb_d;
        end
    end

    assign addr_o   = addr_q;
    assign wdata_o  = wdata_q;
    assign wr_stb_o = wr_stb_q;
    assign pready_o = pready_q;

endmodule

// File: rtl/apb_reg_slave.sv
// rtl/apb_reg_slave.sv - APB completer register bank for panel window/irq/frame control; option APB_ADDR_CHECK_EN
module apb_reg_slave
    import apb_reg_pkg::*;
#(
    parameter logic [7:0]  BASE_PAGE   = 8'h00,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] ID_VALUE    = 32'h4D49_0103
) (
    input  logic        cpuclk,
    input  logic        rst,
    input  logic [19:0] paddr,
    input  logic        psel,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic [7:0]  ctrl_o,
    output logic [31:0] caset_o,
    output logic [31:0] paset_o,
    output logic        win_upd_o,
    input  logic [7:0]  sts_i,
    input  logic [3:0]  irq_src_i,
    input  logic        frame_i,
    output logic        irq_o
);

`ifdef APB_ADDR_CHECK_EN
    localparam int          IRQ_BITS = IRQ_W + 1;
    localparam logic [31:0] MISS_DATA = 32'hDEAD_BEEF;
`else
    localparam int          IRQ_BITS = IRQ_W;
    localparam logic [31:0] MISS_DATA = 32'h0000_0000;
`endif

    logic [19:0] addr_w;
    logic [31:0] wdata_w;
    logic        wr_stb_w;
    logic        pready_w;

    apb_slv_fsm #(
        .WAIT_STATES (WAIT_STATES)
    ) u_fsm (
        .cpuclk   (cpuclk),
        .rst      (rst),
        .psel     (psel),
        .paddr    (paddr),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .addr_o   (addr_w),
        .wdata_o  (wdata_w),
        .wr_stb_o (wr_stb_w),
        .pready_o (pready_w)
    );

    logic [11:0] off;
    logic        hit;
    logic        wr_hit;

    // Byte-offset bits are don't-care; the page must match and the word must be in the map
    assign off    = addr_w[11:0] & 12'hFFC;
    assign hit    = (addr_w[19:12] == BASE_PAGE) && is_mapped(off);
    assign wr_hit = wr_stb_w && hit;

    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [31:0]         caset_q, caset_d;
    logic [31:0]         paset_q, paset_d;
    logic [IRQ_BITS-1:0] irq_q, irq_d;
    logic [IRQ_BITS-1:0] mask_q, mask_d;
    logic [31:0]         scratch_q, scratch_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic                win_upd_q, win_upd_d;
    logic                irq_o_q, irq_o_d;
    logic [IRQ_BITS-1:0] irq_set;
    logic [IRQ_BITS-1:0] irq_clr;
    logic [31:0]         rdata;

`ifdef APB_ADDR_CHECK_EN
    assign irq_set = {pready_w & ~hit, irq_src_i};
`else
    assign irq_set = irq_src_i;
`endif

    // Read mux from the latched address; prdata is forced to 0 outside the pready cycle
    always_comb begin
        rdata = MISS_DATA;
        if (hit) begin
            case (off)
                REG_ID:        rdata = ID_VALUE;
                REG_CTRL:      rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
                REG_CASET:     rdata = caset_q;
                REG_PASET:     rdata = paset_q;
                REG_STATUS:    rdata = {24'd0, sts_i};
                REG_IRQ:       rdata = {{(32-IRQ_BITS){1'b0}}, irq_q};
                REG_IRQ_MASK:  rdata = {{(32-IRQ_BITS){1'b0}}, mask_q};
                REG_SCRATCH:   rdata = scratch_q;
                REG_FRAME_CNT: rdata = {{(32-FRAME_W){1'b0}}, frame_q};
                default:       rdata = MISS_DATA;
            endcase
        end
    end

    assign prdata = pready_w ? rdata : 32'd0;
    assign pready = pready_w;

    // Register file next-state: writes commit at the end of the pready cycle, events set IRQ after clears
    always_comb begin
        ctrl_d    = ctrl_q;
        caset_d   = caset_q;
        paset_d   = paset_q;
        mask_d    = mask_q;
        scratch_d = scratch_q;
        irq_clr   = '0;
        win_upd_d = 1'b0;
        if (wr_hit) begin
            case (off)
                REG_CTRL:     ctrl_d    = wdata_w[CTRL_W-1:0];
                REG_CASET:    caset_d   = wdata_w;
                REG_PASET:    paset_d   = wdata_w;
                REG_IRQ:      irq_clr   = wdata_w[IRQ_BITS-1:0];
                REG_IRQ_MASK: mask_d    = wdata_w[IRQ_BITS-1:0];
                REG_SCRATCH:  scratch_d = wdata_w;
                default:      ;
            endcase
            win_upd_d = (off == REG_CASET) || (off == REG_PASET);
        end
        irq_d   = (irq_q & ~irq_clr) | irq_set;
        frame_d = frame_q + FRAME_W'(frame_i);
        irq_o_d = |(irq_q & mask_q);
    end

    // Register file state
    always_ff @(posedge cpuclk) begin
        if (rst) begin
            ctrl_q    <= '0;
            caset_q   <= '0;
            paset_q   <= '0;
            irq_q     <= '0;
            mask_q    <= '0;
            scratch_q <= '0;
            frame_q   <= '0;
            win_upd_q <= 1'b0;
            irq_o_q   <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            caset_q   <= caset_d;
            paset_q   <= paset_d;
            irq_q     <= irq_d;
            mask_q    <= mask_d;
            scratch_q <= scratch_d;
            frame_q   <= frame_d;
            win_upd_q <= win_upd_d;
            irq_o_q   <= irq_o_d;
        end
    end

    assign ctrl_o    = ctrl_q;
    assign caset_o   = caset_q;
    assign paset_o   = paset_q;
    assign win_upd_o = win_upd_q;
    assign irq_o     = irq_o_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb/tb_apb_reg_slave.sv - randomized self-checking bench for apb_reg_slave against a register-map model
module tb_apb_reg_slave;

    localparam int          WS   = 2;
    localparam logic [31:0] ID_V = 32'h4D49_0103;
`ifdef APB_ADDR_CHECK_EN
    localparam int          IRQ_N  = 5;
    localparam logic [31:0] BAD_RD = 32'hDEAD_BEEF;
`else
    localparam int          IRQ_N  = 4;
    localparam logic [31:0] BAD_RD = 32'h0000_0000;
`endif
    localparam logic [4:0] IRQ_BITS_M = (IRQ_N == 5) ? 5'h1F : 5'h0F;

    logic        cpuclk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] paddr = '0;
    logic        psel = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic [7:0]  ctrl_o;
    logic [31:0] caset_o;
    logic [31:0] paset_o;
    logic        win_upd_o;
    logic [7:0]  sts_i = '0;
    logic [3:0]  irq_src_i = '0;
    logic        frame_i = 1'b0;
    logic        irq_o;

    apb_reg_slave #(
        .BASE_PAGE   (8'h00),
        .WAIT_STATES (WS),
        .ID_VALUE    (ID_V)
    ) dut (
        .cpuclk    (cpuclk),
        .rst       (rst),
        .paddr     (paddr),
        .psel      (psel),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .ctrl_o    (ctrl_o),
        .caset_o   (caset_o),
        .paset_o   (paset_o),
        .win_upd_o (win_upd_o),
        .sts_i     (sts_i),
        .irq_src_i (irq_src_i),
        .frame_i   (frame_i),
        .irq_o     (irq_o)
    );

    always #5 cpuclk = ~cpuclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model: plain register values by name
    logic [7:0]  ctrl_m;
    logic [31:0] caset_m, paset_m, scratch_m;
    logic [4:0]  irq_m, mask_m;
    logic [15:0] frame_m;

    task automatic model_reset();
        ctrl_m = '0; caset_m = '0; paset_m = '0; scratch_m = '0;
        irq_m = '0; mask_m = '0; frame_m = '0;
    endtask

    function automatic logic addr_ok(input logic [19:0] a);
        logic [11:0] off;
        off = {a[11:2], 2'b00};
        return (a[19:12] == 8'h00) && (off <= 12'h020);
    endfunction

    function automatic logic [31:0] model_read(input logic [19:0] a);
        logic [11:0] off;
        off = {a[11:2], 2'b00};
        if (!addr_ok(a)) return BAD_RD;
        case (off)
            12'h000: return ID_V;
            12'h004: return {24'd0, ctrl_m};
            12'h008: return caset_m;
            12'h00C: return paset_m;
            12'h010: return {24'd0, sts_i};
            12'h014: return {27'd0, irq_m};
            12'h018: return {27'd0, mask_m};
            12'h01C: return scratch_m;
            12'h020: return {16'd0, frame_m};
            default: return BAD_RD;
        endcase
    endfunction

    task automatic model_commit(input logic [19:0] a, input logic w, input logic [31:0] d, input logic [3:0] src);
        logic [11:0] off;
        off = {a[11:2], 2'b00};
        if (!addr_ok(a)) begin
            if (IRQ_N == 5) irq_m[4] = 1'b1;
        end else if (w) begin
            case (off)
                12'h004: ctrl_m    = d[7:0];
                12'h008: caset_m   = d;
                12'h00C: paset_m   = d;
                12'h014: irq_m     = irq_m & ~(d[4:0] & IRQ_BITS_M);
                12'h018: mask_m    = d[4:0] & IRQ_BITS_M;
                12'h01C: scratch_m = d;
                default: ;
            endcase
        end
        irq_m = irq_m | {1'b0, src};
    endtask

    // One transfer; checks latency, read data and single-cycle pready; returns at the DONE-cycle negedge
    task automatic xfer(input logic [19:0] a, input logic w, input logic [31:0] d, input logic [3:0] src,
                        output logic [31:0] r);
        int   cyc;
        logic got;
        logic [31:0] exp;
        @(posedge cpuclk); #1;
        paddr = a; pwrite = w; pwdata = d; psel = 1'b1;
        @(posedge cpuclk);
        cyc = 0; got = 1'b0; r = '0;
        while (!got && cyc < 40) begin
            @(negedge cpuclk);
            cyc++;
            if (pready) got = 1'b1;
            else if (cyc == 1) chk("prdata_not_ready", prdata, 32'd0);
        end
        chk("pready_seen", {31'd0, got}, 32'd1);
        chk("pready_latency", cyc, WS + 1);
        r = prdata;
        exp = model_read(a);
        if (!w) chk("read_data", r, exp);
        irq_src_i = src;
        @(posedge cpuclk); #1;
        psel = 1'b0; irq_src_i = '0;
        model_commit(a, w, d, src);
        @(negedge cpuclk);
        chk("pready_one_cycle", {31'd0, pready}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge cpuclk); #1;
        rst = 1'b1; psel = 1'b0;
        repeat (2) @(posedge cpuclk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    logic [31:0] rd;
    logic [19:0] ra;
    logic        rw;
    logic [31:0] rdat;
    logic        win_exp;
    int          seen;

    initial begin
        model_reset();
        repeat (3) @(posedge cpuclk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge cpuclk);
        chk("rst_pready", {31'd0, pready}, 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_ctrl", {24'd0, ctrl_o}, 32'd0);
        chk("rst_caset", caset_o, 32'd0);
        chk("rst_paset", paset_o, 32'd0);
        chk("rst_win_upd", {31'd0, win_upd_o}, 32'd0);
        chk("rst_irq_o", {31'd0, irq_o}, 32'd0);

        // ID read
        xfer(20'h00000, 1'b0, 32'd0, 4'd0, rd);
        chk("id_value", rd, 32'h4D49_0103);

        // CASET write, window-update pulse and readback
        xfer(20'h00008, 1'b1, 32'h0437_0000, 4'd0, rd);
        chk("caset_out", caset_o, 32'h0437_0000);
        chk("caset_win_upd", {31'd0, win_upd_o}, 32'd1);
        @(negedge cpuclk);
        chk("caset_win_upd_end", {31'd0, win_upd_o}, 32'd0);
        xfer(20'h00008, 1'b0, 32'd0, 4'd0, rd);
        xfer(20'h0000C, 1'b1, 32'h0EFF_0010, 4'd0, rd);
        chk("paset_win_upd", {31'd0, win_upd_o}, 32'd1);
        xfer(20'h00008, 1'b1, 32'h0123_0004, 4'd0, rd);
        chk("caset2_win_upd", {31'd0, win_upd_o}, 32'd1);
        chk("paset_out", paset_o, 32'h0EFF_0010);

        // Interrupt set, masked output delay, coincident clear, real clear
        xfer(20'h00018, 1'b1, 32'h2, 4'd0, rd);
        @(posedge cpuclk); #1 irq_src_i = 4'h2;
        @(posedge cpuclk); #1 irq_src_i = 4'h0;
        irq_m = irq_m | 5'h02;
        @(negedge cpuclk);
        chk("irq_o_delay", {31'd0, irq_o}, 32'd0);
        @(negedge cpuclk);
        chk("irq_o_set", {31'd0, irq_o}, 32'd1);
        xfer(20'h00014, 1'b1, 32'h2, 4'h2, rd);
        xfer(20'h00014, 1'b0, 32'd0, 4'd0, rd);
        chk("irq_coincide", rd, 32'h2);
        xfer(20'h00014, 1'b1, 32'h2, 4'd0, rd);
        chk("irq_o_hold", {31'd0, irq_o}, 32'd1);
        @(negedge cpuclk);
        chk("irq_o_clear", {31'd0, irq_o}, 32'd0);

        // Unmapped read and page-mismatch write
        xfer(20'h0001C, 1'b1, 32'h1357_9BDF, 4'd0, rd);
        xfer(20'h00040, 1'b0, 32'd0, 4'd0, rd);
        chk("unmapped_read", rd, BAD_RD);
        xfer(20'h0101C, 1'b1, 32'hFFFF_FFFF, 4'd0, rd);
        xfer(20'h0001C, 1'b0, 32'd0, 4'd0, rd);
        chk("page_miss_scratch", rd, 32'h1357_9BDF);
        xfer(20'h00014, 1'b0, 32'd0, 4'd0, rd);

        // Randomized mixed traffic
        for (int i = 0; i < 60; i++) begin
            sts_i = 8'($urandom);
            ra = {8'd0, 12'($urandom_range(0, 10) * 4)} | 20'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) ra[19:12] = 8'($urandom_range(1, 255));
            rw   = 1'($urandom_range(0, 1));
            rdat = $urandom;
            xfer(ra, rw, rdat, 4'd0, rd);
            win_exp = rw && addr_ok(ra) && ((ra[11:2] == 10'd2) || (ra[11:2] == 10'd3));
            chk("rnd_ctrl", {24'd0, ctrl_o}, {24'd0, ctrl_m});
            chk("rnd_caset", caset_o, caset_m);
            chk("rnd_paset", paset_o, paset_m);
            chk("rnd_win_upd", {31'd0, win_upd_o}, {31'd0, win_exp});
            @(negedge cpuclk);
            chk("rnd_irq_o", {31'd0, irq_o}, {31'd0, |(irq_m & mask_m)});
        end

        // Frame counter wrap
        @(posedge cpuclk); #1 frame_i = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            @(posedge cpuclk);
            frame_m = frame_m + 16'd1;
        end
        #1 frame_i = 1'b0;
        xfer(20'h00020, 1'b1, 32'h0000_FFFF, 4'd0, rd);
        xfer(20'h00020, 1'b0, 32'd0, 4'd0, rd);
        chk("frame_wrap", rd, 32'h0000_0001);

        // Reset during the wait of a SCRATCH write
        @(posedge cpuclk); #1;
        paddr = 20'h0001C; pwrite = 1'b1; pwdata = 32'hA5A5_A5A5; psel = 1'b1;
        @(posedge cpuclk); #1;
        rst = 1'b1; psel = 1'b0;
        @(negedge cpuclk);
        chk("rst_mid_pready", {31'd0, pready}, 32'd0);
        @(posedge cpuclk); #1 rst = 1'b0;
        model_reset();
        seen = 0;
        repeat (5) begin
            @(negedge cpuclk);
            if (pready) seen++;
        end
        chk("rst_mid_no_pready", seen, 0);
        xfer(20'h0001C, 1'b0, 32'd0, 4'd0, rd);
        chk("rst_mid_scratch", rd, 32'd0);
        xfer(20'h0001C, 1'b1, 32'hC3C3_3C3C, 4'd0, rd);
        xfer(20'h0001C, 1'b0, 32'd0, 4'd0, rd);
        chk("after_rst_scratch", rd, 32'hC3C3_3C3C);

        do_reset();
        @(negedge cpuclk);
        chk("final_rst_caset", caset_o, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
